// File: rtl/decode_controller.sv
// Multi-cycle instruction decode controller: sequences fetch, decode, execute,
// memory and write-back phases from a 4-bit opcode and counts retired instructions.
module decode_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  instr_op,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic        alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  imm_src,
    output logic        halted,
    output logic [15:0] retired_count
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StMemAddr,
        StMemRd,
        StWbMem,
        StMemWr,
        StWbAlu,
        StBranch,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] retired_count_q;
    logic        retire;
    logic [1:0]  imm_sel;

    // Sign-extender select depends only on the latched opcode.
    always_comb begin
        imm_sel = 2'b00;
        if (op_q == 4'b0111) begin
            imm_sel = 2'b00;
        end else if (op_q >= 4'b1000 && op_q <= 4'b1101) begin
            imm_sel = 2'b01;
        end else if (op_q == 4'b1110) begin
            imm_sel = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StFetch;
            op_q            <= 4'b0000;
            retired_count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (retire) begin
                retired_count_q <= retired_count_q + 16'h0001;
            end
        end
    end

    assign retired_count = retired_count_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_b  = 1'b0;
        alu_ctrl   = 3'b000;
        imm_src    = 2'b00;
        halted     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    op_d     = instr_op;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                imm_src = imm_sel;
                if (op_q <= 4'b0110) begin
                    state_d = StExecR;
                end else if (op_q <= 4'b1011) begin
                    state_d = StExecI;
                end else if (op_q <= 4'b1101) begin
                    state_d = StMemAddr;
                end else if (op_q == 4'b1110) begin
                    state_d = StBranch;
                end else begin
                    state_d = StHalt;
                end
            end
            StExecR: begin
                imm_src  = imm_sel;
                alu_ctrl = op_q[2:0];
                state_d  = StWbAlu;
            end
            StExecI: begin
                imm_src   = imm_sel;
                alu_src_b = 1'b1;
                alu_ctrl  = op_q[2:0];
                state_d   = StWbAlu;
            end
            StWbAlu: begin
                imm_src   = imm_sel;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StMemAddr: begin
                imm_src   = imm_sel;
                alu_src_b = 1'b1;
                state_d   = (op_q == 4'b1100) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                imm_src  = imm_sel;
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) begin
                    state_d = StWbMem;
                end
            end
            StWbMem: begin
                imm_src    = imm_sel;
                reg_write  = 1'b1;
                result_src = 2'b01;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                imm_src  = imm_sel;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StBranch: begin
                imm_src  = imm_sel;
                alu_ctrl = 3'b001;
                pc_src   = 1'b1;
                pc_write = zero;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset masks every control output so memory never sees a stray request.
        if (rst) begin
            retire     = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_src   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_b  = 1'b0;
            alu_ctrl   = 3'b000;
            imm_src    = 2'b00;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_controller.sv
// Scoreboard bench for decode_controller: driver queues per-cycle expected controls,
// monitor pops and compares on the falling edge.
module tb_decode_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  instr_op;
    logic        mem_ready;
    logic        zero;
    logic        mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0]  result_src;
    logic        alu_src_b;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic        halted;
    logic [15:0] retired_count;

    decode_controller dut (
        .clk           (clk),
        .rst           (rst),
        .instr_op      (instr_op),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_src      (addr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_b     (alu_src_b),
        .alu_ctrl      (alu_ctrl),
        .imm_src       (imm_src),
        .halted        (halted),
        .retired_count (retired_count)
    );

    typedef struct {
        string       name;
        logic [15:0] ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'h0000;

    localparam logic [15:0] Zero16 = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: mem_req mem_we addr_src ir_write pc_write pc_src reg_write
    //            result_src[1:0] alu_src_b alu_ctrl[2:0] imm_src[1:0] halted
    function automatic logic [15:0] mk(input logic mreq, input logic mwe, input logic asrc,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic rw, input logic [1:0] rs, input logic asb,
                                       input logic [2:0] ac, input logic [1:0] is,
                                       input logic h);
        return {mreq, mwe, asrc, irw, pcw, pcs, rw, rs, asb, ac, is, h};
    endfunction

    task automatic step(input logic r, input logic [3:0] op, input logic rdy, input logic z,
                        input string name, input logic [15:0] ctl, input bit ret);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        instr_op  = op;
        mem_ready = rdy;
        zero      = z;
        e.name = name;
        e.ctl  = ctl;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        if (r) exp_cnt = 16'h0000;
        else if (ret) exp_cnt = exp_cnt + 16'h0001;
    endtask

    task automatic fetch(input logic [3:0] op, input int stall);
        for (int i = 0; i < stall; i++)
            step(1'b0, op, 1'b0, 1'b0, "fetch_wait",
                 mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0), 1'b0);
        step(1'b0, op, 1'b1, 1'b0, "fetch",
             mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0), 1'b0);
    endtask

    // ALU instruction; inputs during later cycles are deliberately junk.
    task automatic alu_instr(input logic [3:0] op, input logic [1:0] is, input logic imm,
                             input int stall);
        fetch(op, stall);
        step(1'b0, ~op, 1'b1, 1'b1, "decode",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, is, 0), 1'b0);
        step(1'b0, ~op, 1'b1, 1'b1, "exec",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, imm, op[2:0], is, 0), 1'b0);
        step(1'b0, ~op, 1'b1, 1'b0, "wb_alu",
             mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'b000, is, 0), 1'b1);
    endtask

    task automatic load_instr(input int stall);
        fetch(4'b1100, 0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "ld_decode",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b01, 0), 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "ld_mem_addr",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 3'b000, 2'b01, 0), 1'b0);
        for (int i = 0; i < stall; i++)
            step(1'b0, 4'b0000, 1'b0, 1'b0, "ld_mem_rd_wait",
                 mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b01, 0), 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "ld_mem_rd",
             mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b01, 0), 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "wb_mem",
             mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 3'b000, 2'b01, 0), 1'b0);
        exp_cnt = exp_cnt + 16'h0001;
    endtask

    // Store up to the MEM_WR wait cycles; completes only when finish is set.
    task automatic store_instr(input int stall, input bit finish);
        fetch(4'b1101, 0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "st_decode",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b01, 0), 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "st_mem_addr",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 3'b000, 2'b01, 0), 1'b0);
        for (int i = 0; i < stall; i++)
            step(1'b0, 4'b0000, 1'b0, 1'b0, "st_mem_wr_wait",
                 mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b01, 0), 1'b0);
        if (finish)
            step(1'b0, 4'b0000, 1'b1, 1'b0, "st_mem_wr",
                 mk(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b01, 0), 1'b1);
    endtask

    task automatic branch_instr(input logic z);
        fetch(4'b1110, 0);
        step(1'b0, 4'b0000, 1'b1, ~z, "br_decode",
             mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b10, 0), 1'b0);
        step(1'b0, 4'b0000, 1'b1, z, "branch",
             mk(0, 0, 0, 0, z, 1, 0, 2'b00, 0, 3'b001, 2'b10, 0), 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {mem_req, mem_we, addr_src, ir_write, pc_write, pc_src, reg_write,
                   result_src, alu_src_b, alu_ctrl, imm_src, halted};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl: got %b want %b", e.name, got, e.ctl);
            end
            checks++;
            if (retired_count !== e.cnt) begin
                errors++;
                $display("FAIL %s retired_count: got %h want %h", e.name, retired_count, e.cnt);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        instr_op  = 4'b0000;
        mem_ready = 1'b0;
        zero      = 1'b0;

        step(1'b1, 4'b0010, 1'b1, 1'b0, "reset", Zero16, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 1'b0, "reset", Zero16, 1'b0);

        alu_instr(4'b0010, 2'b00, 1'b0, 0);
        load_instr(3);
        branch_instr(1'b1);
        branch_instr(1'b0);
        alu_instr(4'b1010, 2'b01, 1'b1, 0);
        alu_instr(4'b0101, 2'b00, 1'b0, 2);
        store_instr(2, 1'b1);

        // Preload the counter instead of retiring 65535 instructions.
        @(posedge clk);
        #1;
        force dut.retired_count_q = 16'hFFFF;
        mem_ready = 1'b0;
        exp_cnt   = 16'hFFFF;
        exp_q.push_back('{name: "preload", ctl: mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000,
                                                    2'b00, 0), cnt: exp_cnt});
        @(posedge clk);
        #1;
        release dut.retired_count_q;
        exp_q.push_back('{name: "preload_hold", ctl: mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0,
                                                         3'b000, 2'b00, 0), cnt: exp_cnt});
        alu_instr(4'b0000, 2'b00, 1'b0, 0);

        // Abandon a store mid-wait; counter clears on the reset edge.
        store_instr(2, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0, "st_rst", Zero16, 1'b0);
        step(1'b1, 4'b0000, 1'b1, 1'b0, "st_rst", Zero16, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b0, "post_rst_fetch",
             mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 0), 1'b0);

        alu_instr(4'b0111, 2'b00, 1'b1, 0);
        fetch(4'b1111, 0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, "halt_decode", Zero16, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 4'b0010, 1'b1, 1'b1, "halt",
                 mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 2'b00, 1), 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_controller.md
DECODE_CONTROLLER -- requirements
Module: decode_controller

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 The block SHALL have port instr_op, input, 4, the opcode field instr[31:28] from the memory read bus.
REQ-004 The block SHALL have port mem_ready, input, 1, memory has completed the current request this cycle.
REQ-005 The block SHALL have port zero, input, 1, ALU zero flag.
REQ-006 The block SHALL have outputs mem_req (1), mem_we (1), addr_src (1; 0=PC, 1=ALU result), ir_write (1) and pc_write (1).
REQ-007 The block SHALL have outputs pc_src (1; 0=PC+4, 1=branch target), reg_write (1), result_src (2; 00=ALU, 01=memory) and alu_src_b (1; 0=register, 1=extended immediate).
REQ-008 The block SHALL have outputs alu_ctrl (3), imm_src (2; sign-extender select), halted (1) and retired_count (16).

Function
REQ-009 The block SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, WB_ALU, BRANCH and HALT.
REQ-010 In FETCH: mem_req=1, mem_we=0, addr_src=0; stay while mem_ready=0; on mem_ready=1: ir_write=1, pc_write=1, pc_src=0, latch instr_op into op_q, go DECODE.
REQ-011 DECODE SHALL last exactly one cycle and dispatch on op_q: 0000-0110 -> EXEC_R; 0111 or 1000-1011 -> EXEC_I; 1100, 1101 -> MEM_ADDR; 1110 -> BRANCH; 1111 -> HALT.
REQ-012 imm_src SHALL be a function of op_q, stable from DECODE to instruction end: 0111 -> 00; 1000-1101 -> 01; 1110 -> 10; all others -> 00.
REQ-013 EXEC_R: alu_src_b=0, alu_ctrl=op_q[2:0]; EXEC_I: alu_src_b=1, alu_ctrl=op_q[2:0]; both -> WB_ALU next cycle.
REQ-014 WB_ALU: reg_write=1, result_src=00, -> FETCH.
REQ-015 MEM_ADDR: alu_src_b=1, alu_ctrl=000; -> MEM_RD if op_q=1100, else MEM_WR.
REQ-016 MEM_RD: mem_req=1, mem_we=0, addr_src=1, wait on mem_ready; on mem_ready=1 -> WB_MEM.
REQ-017 WB_MEM: reg_write=1, result_src=01, -> FETCH.
REQ-018 MEM_WR: mem_req=1, mem_we=1, addr_src=1, wait on mem_ready; on mem_ready=1 -> FETCH.
REQ-019 BRANCH: alu_src_b=0, alu_ctrl=001, pc_src=1, pc_write=zero, -> FETCH.
REQ-020 HALT: halted=1, all other control outputs 0; remain until rst.
REQ-021 Outputs not listed for a state SHALL be 0; mem_req SHALL stay 1 continuously while waiting in a memory state.
REQ-022 mem_ready SHALL be ignored outside FETCH, MEM_RD and MEM_WR.
REQ-023 retired_count SHALL increment by 1 in the cycle leaving WB_ALU, WB_MEM, BRANCH, or MEM_WR with mem_ready=1; it SHALL wrap 0xFFFF -> 0x0000 and SHALL not count HALT.
REQ-024 Minimum latencies (mem_ready=1 at first request) SHALL be: R/I 4 cycles, load 5, store 4, branch 3.

Reset
REQ-025 While rst=1, all control outputs and halted SHALL be forced 0.
REQ-026 At the rst edge, state SHALL become FETCH, op_q 0000 and retired_count 0.
REQ-027 Reset mid-transaction (any state, including memory waits) SHALL abandon the instruction; in the first cycle after rst falls, FETCH SHALL assert mem_req=1.

Verification
REQ-028 Reset release with instr_op=0010 and mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_ALU; alu_ctrl=010 in EXEC_R; reg_write=1 in cycle 4; retired_count=1.
REQ-029 instr_op=1100 with mem_ready held 0 for 3 cycles in MEM_RD -> mem_req=1 and addr_src=1 for 4 cycles; imm_src=01; WB_MEM gives result_src=01 and reg_write=1.
REQ-030 instr_op=1110 with zero=1, then with zero=0 -> imm_src=10; pc_src=1 both times; pc_write=1 only when zero=1; 3 cycles each.
REQ-031 instr_op=0111 -> imm_src=00, alu_src_b=1, alu_ctrl=111; then instr_op=1111 -> halted=1 indefinitely, mem_req=0, retired_count unchanged.
REQ-032 Preload retired_count=0xFFFF (65535 ALU instructions), retire one more -> 0x0000.
REQ-033 Assert rst during MEM_WR wait (mem_we=1) -> mem_req and mem_we read 0 during rst; FETCH with mem_req=1 the first cycle after release; retired_count=0.
